// File: rtl/aes_pkg.sv
// aes_pkg: shared types and constants for the AES job sequencer.
//   aes_job_state_t    - job FSM state encoding
//   AES_WORD_W         - width of one result word (32)
//   AES_BLK_W          - width of one AES block (128)
//   AES_TIMEOUT_CYCLES - default wait-state timeout in cycles
//   aes_is_wait()      - 1 for states that wait on BSY and can time out
package aes_pkg;

    localparam int unsigned AES_WORD_W         = 32;
    localparam int unsigned AES_BLK_W          = 128;
    localparam int unsigned AES_TIMEOUT_CYCLES = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_KWAIT,
        ST_DATA,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_CAPTURE
    } aes_job_state_t;

    function automatic logic aes_is_wait(input aes_job_state_t s);
        return (s == ST_KWAIT) || (s == ST_WAIT_HI) || (s == ST_WAIT_LO);
    endfunction

endpackage

// File: rtl/aes_job_timeout.sv
// aes_job_timeout: loadable saturating down-counter with an expire flag.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   load       - reload the counter with load_val on the next edge
//   load_val   - reload value (cycles remaining minus one)
//   expired    - counter has reached zero
module aes_job_timeout #(
    parameter int unsigned W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/aes_job_ctrl.sv
// aes_job_ctrl: turns a software START edge into the Krdy/Drdy/EN handshake
// of the AES core harness, follows the harness BSY, latches the 128-bit
// result and reports sticky DONE/ERR status.
// Ports:
//   CLK, RSTn            - clock, asynchronous active-low reset
//   START, NEWKEY, CLR   - register-bank command bits
//   BSY, OUT_DATA0..3    - registered busy and ciphertext words from the harness
//   Krdy, Drdy, EN       - handshake to the harness
//   RES0..3              - latched result words
//   DONE, ERR, ACTIVE    - status back to the register bank
//   CYCLES               - job latency in cycles
// Optional feature: define AES_JOB_CYCLE_CNT_EN to build the job cycle
// counter; otherwise CYCLES is tied to 0.
module aes_job_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = AES_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  START,
    input  logic                  NEWKEY,
    input  logic                  CLR,
    input  logic                  BSY,
    input  logic [AES_WORD_W-1:0] OUT_DATA0,
    input  logic [AES_WORD_W-1:0] OUT_DATA1,
    input  logic [AES_WORD_W-1:0] OUT_DATA2,
    input  logic [AES_WORD_W-1:0] OUT_DATA3,
    output logic                  Krdy,
    output logic                  Drdy,
    output logic                  EN,
    output logic [AES_WORD_W-1:0] RES0,
    output logic [AES_WORD_W-1:0] RES1,
    output logic [AES_WORD_W-1:0] RES2,
    output logic [AES_WORD_W-1:0] RES3,
    output logic                  DONE,
    output logic                  ERR,
    output logic                  ACTIVE,
    output logic [CNT_W-1:0]      CYCLES
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    aes_job_state_t         state, state_nxt;
    logic                   start_q;
    logic                   launch;
    logic                   capture;
    logic                   timeout;
    logic                   to_load;
    logic                   to_expired;
    logic                   en_q;
    logic                   done_q;
    logic                   err_q;
    logic [AES_BLK_W-1:0]   res_q;

    assign launch = (state == ST_IDLE) && START && !start_q;

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state)
            ST_IDLE:    if (launch) state_nxt = NEWKEY ? ST_KEY : ST_DATA;
            ST_KEY:     state_nxt = ST_KWAIT;
            ST_KWAIT: begin
                if (!BSY) begin
                    state_nxt = ST_DATA;
                end else if (to_expired) begin
                    timeout   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_DATA:    state_nxt = ST_WAIT_HI;
            ST_WAIT_HI: begin
                if (BSY) begin
                    state_nxt = ST_WAIT_LO;
                end else if (to_expired) begin
                    timeout   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_LO: begin
                if (!BSY) begin
                    state_nxt = ST_CAPTURE;
                end else if (to_expired) begin
                    timeout   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                capture   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Reload the timer on the edge that enters any wait state, so the first
    // cycle in the state sees TIMEOUT_CYCLES-1 and the last sees zero.
    assign to_load = aes_is_wait(state_nxt) && (state_nxt != state);

    aes_job_timeout #(
        .W (TO_W)
    ) u_timeout (
        .clk      (CLK),
        .rst_n    (RSTn),
        .load     (to_load),
        .load_val (TO_W'(TIMEOUT_CYCLES - 1)),
        .expired  (to_expired)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state   <= ST_IDLE;
            start_q <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state   <= state_nxt;
            start_q <= START;
            if (launch) begin
                en_q <= 1'b1;
            end else if (capture || timeout) begin
                en_q <= 1'b0;
            end
            // Launch overrides CLR; otherwise CLR drops stale status and a
            // completing job may set its own bit in the same cycle.
            if (launch) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end else begin
                if (CLR) begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                end
                if (capture) done_q <= 1'b1;
                if (timeout) err_q  <= 1'b1;
            end
            if (capture) begin
                res_q <= {OUT_DATA3, OUT_DATA2, OUT_DATA1, OUT_DATA0};
            end
        end
    end

    assign Krdy   = (state == ST_KEY);
    assign Drdy   = (state == ST_DATA);
    assign ACTIVE = (state != ST_IDLE);
    assign EN     = en_q;
    assign DONE   = done_q;
    assign ERR    = err_q;
    assign RES0   = res_q[0*AES_WORD_W +: AES_WORD_W];
    assign RES1   = res_q[1*AES_WORD_W +: AES_WORD_W];
    assign RES2   = res_q[2*AES_WORD_W +: AES_WORD_W];
    assign RES3   = res_q[3*AES_WORD_W +: AES_WORD_W];

`ifdef AES_JOB_CYCLE_CNT_EN
    logic [CNT_W-1:0] cyc_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cyc_q <= '0;
        end else if (launch) begin
            cyc_q <= '0;
        end else if ((state != ST_IDLE) && (cyc_q != '1)) begin
            cyc_q <= cyc_q + 1'b1;
        end
    end

    assign CYCLES = cyc_q;
`else
    assign CYCLES = '0;
`endif

endmodule

// File: tb/tb_aes_job_ctrl.sv
// tb_aes_job_ctrl: directed self-checking bench for aes_job_ctrl with a small
// behavioural harness model driving BSY and OUT_DATA0..3.
module tb_aes_job_ctrl;

    localparam logic [31:0] CT3  = 32'h69c4e0d8;
    localparam logic [31:0] CT2  = 32'h6a7b0430;
    localparam logic [31:0] CT1  = 32'hd8cdb780;
    localparam logic [31:0] CT0  = 32'h70b4c55a;
    localparam logic [31:0] JUNK = 32'hdeadbeef;

    logic        CLK = 1'b0;
    logic        RSTn, START, NEWKEY, CLR;
    logic        BSY;
    logic [31:0] OUT_DATA0, OUT_DATA1, OUT_DATA2, OUT_DATA3;
    logic        Krdy, Drdy, EN, DONE, ERR, ACTIVE;
    logic [31:0] RES0, RES1, RES2, RES3;
    logic [15:0] CYCLES;

    int total = 0;
    int bad   = 0;

    bit key_busy = 1'b1;
    bit stuck    = 1'b0;

    int krdy_total = 0, drdy_total = 0, overlap = 0, both = 0;
    int launches = 0, active_run = 0;
    logic prev_active = 1'b0;

    int job1_cycles, job2_cycles;

    always #5 CLK = ~CLK;

    aes_job_ctrl #(
        .TIMEOUT_CYCLES (64),
        .CNT_W          (16)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .START     (START),
        .NEWKEY    (NEWKEY),
        .CLR       (CLR),
        .BSY       (BSY),
        .OUT_DATA0 (OUT_DATA0),
        .OUT_DATA1 (OUT_DATA1),
        .OUT_DATA2 (OUT_DATA2),
        .OUT_DATA3 (OUT_DATA3),
        .Krdy      (Krdy),
        .Drdy      (Drdy),
        .EN        (EN),
        .RES0      (RES0),
        .RES1      (RES1),
        .RES2      (RES2),
        .RES3      (RES3),
        .DONE      (DONE),
        .ERR       (ERR),
        .ACTIVE    (ACTIVE),
        .CYCLES    (CYCLES)
    );

    // Harness model: registered BSY; 3 busy cycles after Krdy, 5 after Drdy,
    // with the ciphertext appearing on the edge where BSY falls.
    logic [3:0] bcnt;
    logic       pend;
    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            BSY <= 1'b0; bcnt <= '0; pend <= 1'b0;
            OUT_DATA0 <= JUNK; OUT_DATA1 <= JUNK; OUT_DATA2 <= JUNK; OUT_DATA3 <= JUNK;
        end else if (Krdy && key_busy) begin
            BSY <= 1'b1; bcnt <= 4'd3;
        end else if (Drdy) begin
            OUT_DATA0 <= JUNK; OUT_DATA1 <= JUNK; OUT_DATA2 <= JUNK; OUT_DATA3 <= JUNK;
            if (!stuck) begin
                BSY <= 1'b1; bcnt <= 4'd5; pend <= 1'b1;
            end
        end else if (BSY) begin
            if (bcnt == 4'd1) begin
                BSY <= 1'b0;
                if (pend) begin
                    OUT_DATA0 <= CT0; OUT_DATA1 <= CT1; OUT_DATA2 <= CT2; OUT_DATA3 <= CT3;
                    pend <= 1'b0;
                end
            end
            bcnt <= bcnt - 4'd1;
        end
    end

    // Passive monitor of handshake pulses, launches and per-job active cycles.
    always @(negedge CLK) begin
        if (Krdy) krdy_total++;
        if (Drdy) drdy_total++;
        if (Krdy && Drdy) overlap++;
        if (DONE && ERR) both++;
        if (ACTIVE && !prev_active) begin
            launches++;
            active_run = 1;
        end else if (ACTIVE) begin
            active_run++;
        end
        prev_active = ACTIVE;
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (ACTIVE && n < 200) begin
            @(negedge CLK);
            n++;
        end
        total++;
        if (ACTIVE !== 1'b0) begin
            bad++;
            $display("FAIL %s: ACTIVE=%b after %0d cycles, required 0", name, ACTIVE, n);
        end
    endtask

    task automatic check_res(input string name);
        total++;
        if ({RES3, RES2, RES1, RES0} !== {CT3, CT2, CT1, CT0}) begin
            bad++;
            $display("FAIL %s: RES=%h %h %h %h required %h %h %h %h",
                     name, RES3, RES2, RES1, RES0, CT3, CT2, CT1, CT0);
        end
    endtask

    task automatic test_reset;
        RSTn = 1'b0; START = 1'b0; NEWKEY = 1'b0; CLR = 1'b0;
        repeat (3) @(negedge CLK);
        total++;
        if ({Krdy, Drdy, EN, DONE, ERR, ACTIVE} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: {Krdy,Drdy,EN,DONE,ERR,ACTIVE}=%b required 000000",
                     {Krdy, Drdy, EN, DONE, ERR, ACTIVE});
        end
        total++;
        if ({RES3, RES2, RES1, RES0, CYCLES} !== '0) begin
            bad++;
            $display("FAIL reset_res: RES=%h %h %h %h CYCLES=%0d required all 0",
                     RES3, RES2, RES1, RES0, CYCLES);
        end
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);
        total++;
        if (ACTIVE !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: ACTIVE=%b required 0 with no START edge", ACTIVE);
        end
    endtask

    task automatic test_key_encrypt;
        int k0, d0;
        key_busy = 1'b1; stuck = 1'b0;
        k0 = krdy_total; d0 = drdy_total;
        NEWKEY = 1'b1; START = 1'b1;
        @(negedge CLK);
        total++;
        if ({EN, Krdy, Drdy, ACTIVE} !== 4'b1101) begin
            bad++;
            $display("FAIL key_launch: {EN,Krdy,Drdy,ACTIVE}=%b required 1101",
                     {EN, Krdy, Drdy, ACTIVE});
        end
        START = 1'b0;
        wait_idle("key_job_end");
        job1_cycles = active_run;
        total++;
        if ((krdy_total - k0) != 1 || (drdy_total - d0) != 1) begin
            bad++;
            $display("FAIL key_pulses: Krdy cycles=%0d Drdy cycles=%0d required 1 and 1",
                     krdy_total - k0, drdy_total - d0);
        end
        check_res("key_res");
        total++;
        if ({DONE, ERR, EN} !== 3'b100) begin
            bad++;
            $display("FAIL key_status: {DONE,ERR,EN}=%b required 100", {DONE, ERR, EN});
        end
    endtask

    task automatic test_key_reuse;
        int k0;
        k0 = krdy_total;
        @(negedge CLK);
        NEWKEY = 1'b0; START = 1'b1;
        @(negedge CLK);
        total++;
        if ({EN, Krdy, Drdy} !== 3'b101) begin
            bad++;
            $display("FAIL reuse_launch: {EN,Krdy,Drdy}=%b required 101", {EN, Krdy, Drdy});
        end
        START = 1'b0;
        wait_idle("reuse_job_end");
        job2_cycles = active_run;
        total++;
        if (krdy_total != k0) begin
            bad++;
            $display("FAIL reuse_no_krdy: Krdy cycles=%0d required 0", krdy_total - k0);
        end
        check_res("reuse_res");
        total++;
        if ({DONE, ERR} !== 2'b10) begin
            bad++;
            $display("FAIL reuse_status: {DONE,ERR}=%b required 10", {DONE, ERR});
        end
`ifdef AES_JOB_CYCLE_CNT_EN
        total++;
        if (CYCLES !== 16'(job2_cycles) || job2_cycles >= job1_cycles) begin
            bad++;
            $display("FAIL reuse_cycles: CYCLES=%0d job1=%0d required %0d and below job1",
                     CYCLES, job1_cycles, job2_cycles);
        end
`else
        total++;
        if (CYCLES !== 16'd0) begin
            bad++;
            $display("FAIL reuse_cycles: CYCLES=%0d required 0", CYCLES);
        end
`endif
    endtask

    task automatic test_timeout;
        stuck = 1'b1;
        @(negedge CLK);
        NEWKEY = 1'b0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        total++;
        if (Drdy !== 1'b1) begin
            bad++;
            $display("FAIL to_drdy: Drdy=%b required 1", Drdy);
        end
        @(negedge CLK);           // first cycle in WAIT_HI
        repeat (63) @(negedge CLK);
        total++;
        if ({ERR, ACTIVE} !== 2'b01) begin
            bad++;
            $display("FAIL to_early: after 63 cycles {ERR,ACTIVE}=%b required 01", {ERR, ACTIVE});
        end
        @(negedge CLK);
        total++;
        if ({ERR, DONE, ACTIVE, EN} !== 4'b1000) begin
            bad++;
            $display("FAIL to_fire: after 64 cycles {ERR,DONE,ACTIVE,EN}=%b required 1000",
                     {ERR, DONE, ACTIVE, EN});
        end
        check_res("to_res_kept");
        stuck = 1'b0;
    endtask

    task automatic test_start_hold;
        int l0;
        l0 = launches;
        @(negedge CLK);
        NEWKEY = 1'b0; START = 1'b1;
        repeat (60) @(negedge CLK);
        total++;
        if ((launches - l0) != 1 || ACTIVE !== 1'b0) begin
            bad++;
            $display("FAIL hold_once: launches=%0d ACTIVE=%b required 1 and 0", launches - l0, ACTIVE);
        end
        START = 1'b0;
        @(negedge CLK);
        START = 1'b1;
        repeat (3) @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        START = 1'b1;             // edge while the job is still running
        wait_idle("hold_job_end");
        repeat (30) @(negedge CLK);
        total++;
        if ((launches - l0) != 2 || DONE !== 1'b1) begin
            bad++;
            $display("FAIL hold_midjob_edge: launches=%0d DONE=%b required 2 and 1", launches - l0, DONE);
        end
        START = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset_mid;
        int n = 0;
        @(negedge CLK);
        NEWKEY = 1'b0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        while (BSY !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);           // now in WAIT_LO
        total++;
        if ({ACTIVE, BSY} !== 2'b11) begin
            bad++;
            $display("FAIL rmid_setup: {ACTIVE,BSY}=%b required 11", {ACTIVE, BSY});
        end
        #1 RSTn = 1'b0;
        #1;
        total++;
        if ({Krdy, Drdy, EN, DONE, ERR, ACTIVE} !== 6'b0 ||
            {RES3, RES2, RES1, RES0, CYCLES} !== '0) begin
            bad++;
            $display("FAIL rmid_async: ctrl=%b RES=%h %h %h %h CYCLES=%0d required all 0",
                     {Krdy, Drdy, EN, DONE, ERR, ACTIVE}, RES3, RES2, RES1, RES0, CYCLES);
        end
        @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_idle("rmid_job_end");
        check_res("rmid_res");
        total++;
        if ({DONE, ERR} !== 2'b10) begin
            bad++;
            $display("FAIL rmid_status: {DONE,ERR}=%b required 10", {DONE, ERR});
        end
    endtask

    task automatic test_clr_collision;
        int n = 0;
        bit early = 1'b0;
        @(negedge CLK);
        CLR = 1'b1; START = 1'b1; NEWKEY = 1'b0;
        @(negedge CLK);
        CLR = 1'b0; START = 1'b0;
        total++;
        if ({DONE, ERR, ACTIVE} !== 3'b001) begin
            bad++;
            $display("FAIL clr_launch: {DONE,ERR,ACTIVE}=%b required 001", {DONE, ERR, ACTIVE});
        end
        while (ACTIVE && n < 200) begin
            if (DONE) early = 1'b1;
            @(negedge CLK);
            n++;
        end
        total++;
        if (early || DONE !== 1'b1 || ACTIVE !== 1'b0) begin
            bad++;
            $display("FAIL clr_done: DONE during job=%b DONE=%b ACTIVE=%b required 0 1 0",
                     early, DONE, ACTIVE);
        end
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        total++;
        if ({DONE, ERR, ACTIVE} !== 3'b000) begin
            bad++;
            $display("FAIL clr_idle: {DONE,ERR,ACTIVE}=%b required 000", {DONE, ERR, ACTIVE});
        end
    endtask

    initial begin
        test_reset;
        test_key_encrypt;
        test_key_reuse;
        test_timeout;
        test_start_hold;
        test_reset_mid;
        test_clr_collision;
        total++;
        if (overlap != 0 || both != 0) begin
            bad++;
            $display("FAIL exclusive: Krdy&Drdy cycles=%0d DONE&ERR cycles=%0d required 0 and 0",
                     overlap, both);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
